// File: rtl/vmcoffee_pkg.sv
// ---------------------------------------------------------------------------
// vmcoffee_pkg
//   Shared definitions for the coffee brew sequencer:
//     state_e        - sequencer state encoding (binary)
//     T_*_DEF        - default phase lengths in clock cycles
//     MIN_WATER_DEF  - default minimum tank level that permits a brew
//     PHASE_W        - phase counter width (phase lengths are 1..15)
//     WATER_W/CUPS_W - widths of the tank level and cup counter
// ---------------------------------------------------------------------------
package vmcoffee_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRIND = 3'd1,
        ST_HEAT  = 3'd2,
        ST_POUR  = 3'd3,
        ST_FIN   = 3'd4,
        ST_FAULT = 3'd5
    } state_e;

    localparam int T_GRIND_DEF   = 4;
    localparam int T_HEAT_DEF    = 6;
    localparam int T_POUR_DEF    = 3;
    localparam int MIN_WATER_DEF = 2;

    localparam int PHASE_W = 4;
    localparam int WATER_W = 5;
    localparam int CUPS_W  = 8;

endpackage

// File: rtl/vmbrew_timer.sv
// ---------------------------------------------------------------------------
// vmbrew_timer
//   Down-counting phase timer shared by all timed brew phases.
//   Ports:
//     clk, rstn    - clock, asynchronous active-low reset (counter -> 0)
//     load_val_i   - phase length in cycles, captured when load_i is high
//     load_i       - load strobe, asserted on the edge that enters a phase
//     expire_o     - high in the last cycle of the phase (counter == 1)
//   A phase loaded with N therefore lasts exactly N cycles.
// ---------------------------------------------------------------------------
module vmbrew_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] load_val_i,
    input  logic         load_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/vmbrew_seq.sv
// ---------------------------------------------------------------------------
// vmbrew_seq
//   Coffee brew sequencer: IDLE -> GRIND -> HEAT -> POUR -> FIN -> IDLE,
//   with FAULT on missing water/beans. One request may queue while busy.
//   Ports:
//     clk, rstn   - clock, asynchronous active-low reset
//     COFFEE      - brew request level; each rising edge is one request
//     WATER[4:0]  - tank level
//     BEANS       - bean sensor, 1 = beans present
//     GRIND/HEAT/PUMP - actuator enables, high only in their own phase
//     BUSY        - high whenever not IDLE
//     DONE        - one-cycle pulse in FIN
//     FAULT       - high in FAULT
//     CUPS[7:0]   - completed cups, saturating at 255
//     state_o     - current state, for debug/observation
// ---------------------------------------------------------------------------
module vmbrew_seq
    import vmcoffee_pkg::*;
#(
    parameter int T_GRIND   = T_GRIND_DEF,
    parameter int T_HEAT    = T_HEAT_DEF,
    parameter int T_POUR    = T_POUR_DEF,
    parameter int MIN_WATER = MIN_WATER_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               COFFEE,
    input  logic [WATER_W-1:0] WATER,
    input  logic               BEANS,
    output logic               GRIND,
    output logic               HEAT,
    output logic               PUMP,
    output logic               BUSY,
    output logic               DONE,
    output logic               FAULT,
    output logic [CUPS_W-1:0]  CUPS,
    output state_e             state_o
);

    localparam logic [PHASE_W-1:0] LD_GRIND = PHASE_W'(T_GRIND);
    localparam logic [PHASE_W-1:0] LD_HEAT  = PHASE_W'(T_HEAT);
    localparam logic [PHASE_W-1:0] LD_POUR  = PHASE_W'(T_POUR);
    localparam logic [WATER_W-1:0] MIN_W    = WATER_W'(MIN_WATER);

    state_e              state_q, state_d;
    logic                coffee_q;
    logic                armed_q;
    logic                pend_q, pend_d;
    logic [CUPS_W-1:0]   cups_q, cups_d;

    logic                req;
    logic                ok_to_brew;
    logic                tmr_load;
    logic [PHASE_W-1:0]  tmr_val;
    logic                tmr_exp;

    // armed_q stays low after reset until COFFEE has been seen low, so a
    // level already held high across reset is not mistaken for a new edge.
    assign req        = COFFEE & ~coffee_q & armed_q;
    assign ok_to_brew = (WATER >= MIN_W) && BEANS;

    vmbrew_timer #(
        .W (PHASE_W)
    ) u_timer (
        .clk        (clk),
        .rstn       (rstn),
        .load_val_i (tmr_val),
        .load_i     (tmr_load),
        .expire_o   (tmr_exp)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            coffee_q <= 1'b0;
            armed_q  <= 1'b0;
            pend_q   <= 1'b0;
            cups_q   <= '0;
        end else begin
            state_q  <= state_d;
            coffee_q <= COFFEE;
            armed_q  <= armed_q | ~COFFEE;
            pend_q   <= pend_d;
            cups_q   <= cups_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        cups_d   = cups_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        // Every request first lands in the pending flag; IDLE acts on the
        // flag one cycle later. Extra requests while it is set are dropped.
        if (req) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d = ok_to_brew ? ST_GRIND : ST_FAULT;
                    pend_d  = req;
                end
            end
            ST_GRIND: begin
                if (!BEANS) begin
                    state_d = ST_FAULT;
                end else if (tmr_exp) begin
                    state_d = ST_HEAT;
                end
            end
            ST_HEAT: begin
                if (WATER == '0) begin
                    state_d = ST_FAULT;
                end else if (tmr_exp) begin
                    state_d = ST_POUR;
                end
            end
            ST_POUR: begin
                if (WATER == '0) begin
                    state_d = ST_FAULT;
                end else if (tmr_exp) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                pend_d = 1'b0;
                if (ok_to_brew) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
            end
        endcase

        // Reload the phase counter on entry into each timed phase.
        if (state_d != state_q) begin
            case (state_d)
                ST_GRIND: begin tmr_load = 1'b1; tmr_val = LD_GRIND; end
                ST_HEAT:  begin tmr_load = 1'b1; tmr_val = LD_HEAT;  end
                ST_POUR:  begin tmr_load = 1'b1; tmr_val = LD_POUR;  end
                default:  begin tmr_load = 1'b0; tmr_val = '0;       end
            endcase
        end

        // Count the cup on entry to FIN so CUPS is already updated while
        // DONE is high.
        if (state_d == ST_FIN && state_q != ST_FIN && cups_q != '1) begin
            cups_d = cups_q + CUPS_W'(1);
        end
    end

    assign GRIND   = (state_q == ST_GRIND);
    assign HEAT    = (state_q == ST_HEAT);
    assign PUMP    = (state_q == ST_POUR);
    assign BUSY    = (state_q != ST_IDLE);
    assign DONE    = (state_q == ST_FIN);
    assign FAULT   = (state_q == ST_FAULT);
    assign CUPS    = cups_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_vmbrew_seq.sv
// ---------------------------------------------------------------------------
// tb_vmbrew_seq
//   Directed bench for vmbrew_seq. The stimulus thread pushes the expected
//   completion cycle and CUPS value for every cup it starts; the monitor
//   pops on each DONE pulse. Inputs change on the falling edge; outputs are
//   sampled on the falling edge. A request driven at falling edge c is
//   sampled at rising edge c+1, so DONE is expected in cycle c+15.
// ---------------------------------------------------------------------------
module tb_vmbrew_seq;
    import vmcoffee_pkg::*;

    localparam int TG = 4;
    localparam int TH = 6;
    localparam int TP = 3;

    logic        clk;
    logic        rstn;
    logic        COFFEE;
    logic [4:0]  WATER;
    logic        BEANS;
    logic        GRIND, HEAT, PUMP, BUSY, DONE, FAULT;
    logic [7:0]  CUPS;
    state_e      st_dbg;

    int          cyc;
    int          total;
    int          bad;
    int          cups_m;

    logic [31:0] exp_cyc_q[$];
    logic [7:0]  exp_cups_q[$];

    vmbrew_seq #(
        .T_GRIND   (TG),
        .T_HEAT    (TH),
        .T_POUR    (TP),
        .MIN_WATER (2)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .COFFEE  (COFFEE),
        .WATER   (WATER),
        .BEANS   (BEANS),
        .GRIND   (GRIND),
        .HEAT    (HEAT),
        .PUMP    (PUMP),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .FAULT   (FAULT),
        .CUPS    (CUPS),
        .state_o (st_dbg)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // low for one cycle, then high: returns the cycle the edge was driven
    task automatic raise(output int c);
        @(negedge clk);
        COFFEE = 1'b0;
        @(negedge clk);
        COFFEE = 1'b1;
        c = cyc;
    endtask

    task automatic expect_cup(input int c);
        cups_m = (cups_m == 255) ? 255 : cups_m + 1;
        exp_cyc_q.push_back(32'(c + TG + TH + TP + 2));
        exp_cups_q.push_back(8'(cups_m));
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [31:0] ec;
        logic [7:0]  ek;
        chk("actuator_exclusive", int'($countones({GRIND, HEAT, PUMP}) <= 1), 1);
        if (DONE) begin
            if (exp_cyc_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                ec = exp_cyc_q.pop_front();
                ek = exp_cups_q.pop_front();
                chk("done_cycle", cyc, int'(ec));
                chk("done_cups", int'(CUPS), int'(ek));
            end
        end
    end

    initial begin
        int c;
        total  = 0;
        bad    = 0;
        cups_m = 0;
        rstn   = 1'b0;
        COFFEE = 1'b0;
        WATER  = 5'd30;
        BEANS  = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_state", int'(st_dbg), int'(ST_IDLE));
        chk("rst_outs", int'({GRIND, HEAT, PUMP, BUSY, DONE, FAULT}), 0);
        chk("rst_cups", int'(CUPS), 0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", int'(BUSY), 0);

        // single full brew, phase by phase
        raise(c);
        expect_cup(c);
        for (int t = 1; t <= 16; t++) begin
            wait_to(c + t);
            chk("brew_grind", int'(GRIND), int'(t >= 2 && t <= 1 + TG));
            chk("brew_heat", int'(HEAT), int'(t >= 2 + TG && t <= 1 + TG + TH));
            chk("brew_pump", int'(PUMP), int'(t >= 2 + TG + TH && t <= 1 + TG + TH + TP));
            chk("brew_busy", int'(BUSY), int'(t >= 2 && t <= 2 + TG + TH + TP));
        end
        chk("brew_cups", int'(CUPS), 1);

        // low water -> FAULT, then recover
        WATER = 5'd1;
        raise(c);
        wait_to(c + 1);
        chk("lowwater_not_yet", int'(FAULT), 0);
        wait_to(c + 2);
        chk("lowwater_fault", int'(FAULT), 1);
        chk("lowwater_act", int'({GRIND, HEAT, PUMP}), 0);
        WATER = 5'd30;
        wait_to(c + 3);
        chk("lowwater_exit", int'(FAULT), 0);
        chk("lowwater_idle", int'(BUSY), 0);

        // queued request during HEAT, dropped one during POUR
        raise(c);
        expect_cup(c);
        wait_to(c + 3);  COFFEE = 1'b0;
        wait_to(c + 7);  COFFEE = 1'b1;
        wait_to(c + 9);  COFFEE = 1'b0;
        wait_to(c + 12); COFFEE = 1'b1;
        expect_cup(c + 15);
        wait_to(c + 16);
        chk("queue_gap_idle", int'(BUSY), 0);
        wait_to(c + 17);
        chk("queue_second_grind", int'(GRIND), 1);
        wait_to(c + 33);
        chk("queue_no_third", int'(BUSY), 0);
        chk("queue_cups", int'(CUPS), 3);

        // beans lost in second GRIND cycle
        raise(c);
        wait_to(c + 3);
        chk("beans_grind", int'(GRIND), 1);
        BEANS = 1'b0;
        wait_to(c + 4);
        chk("beans_fault", int'(FAULT), 1);
        chk("beans_grind_off", int'(GRIND), 0);
        BEANS = 1'b1;
        wait_to(c + 5);
        chk("beans_exit", int'(BUSY), 0);
        wait_to(c + 20);
        chk("beans_cups", int'(CUPS), 3);

        // water lost during HEAT
        raise(c);
        wait_to(c + 7);
        chk("water_heat", int'(HEAT), 1);
        WATER = 5'd0;
        wait_to(c + 8);
        chk("water_fault", int'(FAULT), 1);
        chk("water_heat_off", int'(HEAT), 0);
        WATER = 5'd30;
        wait_to(c + 9);
        chk("water_exit", int'(BUSY), 0);
        chk("water_cups", int'(CUPS), 3);

        // reset mid-POUR with COFFEE held high across it
        raise(c);
        wait_to(c + 13);
        chk("rst_pour_on", int'(PUMP), 1);
        rstn = 1'b0;
        #1;
        chk("rst_pour_pump", int'(PUMP), 0);
        chk("rst_pour_busy", int'(BUSY), 0);
        chk("rst_pour_cups", int'(CUPS), 0);
        cups_m = 0;
        @(negedge clk);
        rstn = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            chk("held_coffee_idle", int'(BUSY), 0);
        end

        // 256 cups: counter saturates at 255, DONE still pulses
        for (int i = 0; i < 256; i++) begin
            raise(c);
            expect_cup(c);
            wait_to(c + 16);
        end
        chk("sat_cups", int'(CUPS), 255);

        repeat (5) @(negedge clk);
        chk("missing_done", exp_cyc_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vmbrew_seq.md
VMBREW_SEQ -- requirements
Module: vmbrew_seq

Interface
REQ-001 Parameter T_GRIND, default 4, grind phase length in clock cycles (1..15).
REQ-002 Parameter T_HEAT, default 6, heat phase length in clock cycles (1..15).
REQ-003 Parameter T_POUR, default 3, pour phase length in clock cycles (1..15).
REQ-004 Parameter MIN_WATER, default 2, minimum WATER level that permits a brew.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 COFFEE  in  1  brew request from the vending controller; level signal, rising edge = one request.
REQ-008 WATER  in  5  tank level, unsigned.
REQ-009 BEANS  in  1  bean sensor: 1 = beans present.
REQ-010 GRIND  out  1  grinder motor enable.
REQ-011 HEAT  out  1  boiler heater enable.
REQ-012 PUMP  out  1  pour pump enable.
REQ-013 BUSY  out  1  high in any state other than IDLE.
REQ-014 DONE  out  1  single-cycle pulse marking cup completion.
REQ-015 FAULT  out  1  high while in FAULT state.
REQ-016 CUPS  out  8  count of completed cups, saturating.

Function
REQ-017 The block SHALL implement states IDLE, GRIND, HEAT, POUR, FIN, FAULT, one-hot or binary encoded.
REQ-018 A request SHALL be a COFFEE rising edge, detected with a registered copy of COFFEE; a held-high COFFEE is one request.
REQ-019 In IDLE, on a request or a set pending flag: if WATER>=MIN_WATER and BEANS=1 -> GRIND, otherwise -> FAULT; pending is cleared in either case.
REQ-020 GRIND, HEAT and POUR SHALL each last exactly T_GRIND, T_HEAT and T_POUR cycles, timed by one phase counter reloaded on every state entry.
REQ-021 GRIND, HEAT and PUMP SHALL be high exactly in GRIND, HEAT and POUR respectively; at most one of them is high in any cycle.
REQ-022 POUR expiry -> FIN; FIN lasts one cycle with DONE=1 and increments CUPS (holds at 255), then -> IDLE.
REQ-023 Latency: request edge sampled at edge k -> DONE high in cycle k+T_GRIND+T_HEAT+T_POUR+1 (k+14 at defaults).
REQ-024 A request arriving while BUSY SHALL set the pending flag; further requests while pending is set are dropped (depth-1 queue).
REQ-025 A pending request SHALL start from IDLE in the cycle after FIN, using the same checks as REQ-019.
REQ-026 BEANS=0 during GRIND, or WATER=0 during HEAT or POUR, SHALL abort to FAULT on the next edge; the pump/grinder/heater output drops in that cycle.
REQ-027 In FAULT, all actuator outputs are 0 and pending is cleared; exit to IDLE when WATER>=MIN_WATER and BEANS=1; requests during FAULT are ignored.
REQ-028 An aborted cup SHALL NOT produce DONE and SHALL NOT increment CUPS.
REQ-029 A request edge coinciding with FIN SHALL set pending, not be lost.

Reset
REQ-030 rstn low SHALL immediately force state IDLE, phase counter 0, pending 0, COFFEE edge register 0, CUPS 0, and all outputs 0.
REQ-031 Reset asserted mid-brew SHALL drop the actuator outputs without waiting for a clock edge; no DONE follows.
REQ-032 After rstn rises, a COFFEE level already high SHALL NOT count as a request until it falls and rises again.

Structure
REQ-033 The state encoding and the default timing constants SHALL live in shared package vmcoffee_pkg.
REQ-034 The phase counter SHALL be a sub-module vmbrew_timer (load value, load strobe, expire flag).

Verification
REQ-035 Reset, then COFFEE 0->1 with WATER=30, BEANS=1 -> GRIND high for 4 cycles, HEAT for 6, PUMP for 3, DONE pulse at sampled edge +14, CUPS=1.
REQ-036 COFFEE rising with WATER=1 -> FAULT=1 next cycle, no actuator output; WATER set to 30 -> IDLE next cycle, FAULT=0.
REQ-037 Second COFFEE edge during HEAT, third during POUR -> exactly two cups, second GRIND begins 2 cycles after first DONE, CUPS=2.
REQ-038 BEANS dropped to 0 in cycle 2 of GRIND -> FAULT, no DONE, CUPS unchanged; BEANS=1 -> IDLE.
REQ-039 rstn pulsed low during POUR -> PUMP=0 asynchronously, CUPS=0, BUSY=0; COFFEE held high across reset produces no brew.
REQ-040 Preload CUPS to 255 via 255 cups (or force), one more cup -> DONE pulses, CUPS stays 255.
